// File: rtl/pong_pkg.sv
// Shared state encoding and playfield geometry for the Pong engine.
// All coordinates are top-left pixel positions on a 640x480 screen.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } pong_state_t;

  localparam int BALL_SIZE  = 8;
  localparam int PAD_H      = 64;
  localparam int PAD_L_X0   = 16;
  localparam int PAD_L_X1   = 23;
  localparam int PAD_R_X0   = 616;
  localparam int PAD_R_X1   = 623;
  localparam int PAD_Y_MAX  = 416;
  localparam int PAD_Y_RST  = 208;
  localparam int BALL_X_C   = 316;
  localparam int BALL_Y_C   = 236;
  localparam int BALL_X_MAX = 632;
  localparam int BALL_Y_MAX = 472;
  localparam int LINE_X0    = 319;
  localparam int LINE_X1    = 320;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/pong_paddle_ctrl.sv
// One paddle's vertical position; steps once per frame tick and
// saturates at the top and bottom of the playfield.
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int SPEED = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       en,
  input  logic       up,
  input  logic       dn,
  output logic [8:0] pad_y
);

  logic [8:0] pad_y_q, pad_y_d;
  logic [9:0] pad_dn;

  always_comb begin
    pad_y_d = pad_y_q;
    pad_dn  = {1'b0, pad_y_q} + 10'(SPEED);
    // both buttons or neither means hold
    if (tick && en && (up != dn)) begin
      if (up) begin
        pad_y_d = (pad_y_q >= 9'(SPEED)) ? pad_y_q - 9'(SPEED) : 9'd0;
      end else begin
        pad_y_d = (pad_dn > 10'(PAD_Y_MAX)) ? 9'(PAD_Y_MAX) : pad_dn[8:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pad_y_q <= 9'(PAD_Y_RST);
    end else begin
      pad_y_q <= pad_y_d;
    end
  end

  assign pad_y = pad_y_q;

endmodule

// File: rtl/pong_engine.sv
// Pong game state (ball, paddles, score) advanced once per frame on the VS
// falling edge, plus the registered pixel-colour mux.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | ball parked at centre, waiting for serve on a tick
// ST_PLAY  | ball moving, walls/paddles reflect, misses score
// ST_POINT | ball frozen while the hold counter runs down
// ST_OVER  | a player reached WIN_SCORE, serve restarts the match
module pong_engine
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_SPEED = 4,
  parameter int POINT_HOLD   = 60
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       VS,
  input  logic       blank,
  input  logic [8:0] row,
  input  logic [9:0] col,
  input  logic       l_up,
  input  logic       l_dn,
  input  logic       r_up,
  input  logic       r_dn,
  input  logic       serve,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over
);

  localparam int HW = (POINT_HOLD > 1) ? $clog2(POINT_HOLD) : 1;

  localparam logic signed [10:0] S_SPD    = 11'(BALL_SPEED);
  localparam logic signed [10:0] S_X_MAX  = 11'(BALL_X_MAX);
  localparam logic signed [10:0] S_Y_MAX  = 11'(BALL_Y_MAX);
  localparam logic signed [10:0] S_PL_X1  = 11'(PAD_L_X1);
  localparam logic signed [10:0] S_PR_X0  = 11'(PAD_R_X0);
  localparam logic signed [10:0] S_B7     = 11'(BALL_SIZE - 1);
  localparam logic signed [10:0] S_PH1    = 11'(PAD_H - 1);

  pong_state_t   state_q, state_d;
  logic          vs_prev_q;
  logic          tick;
  logic [9:0]    bx_q, bx_d;
  logic [8:0]    by_q, by_d;
  logic          dx_pos_q, dx_pos_d;
  logic          dy_pos_q, dy_pos_d;
  logic [3:0]    score_l_q, score_l_d;
  logic [3:0]    score_r_q, score_r_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          game_over_q, game_over_d;
  logic [23:0]   rgb_q, rgb_d;

  logic [8:0]    pad_l_y, pad_r_y;
  logic          pad_en;

  logic signed [10:0] bx_s, by_s, pl_s, pr_s, nx, ny;
  logic               hit_l, hit_r, miss_l, miss_r;
  logic               ball_px, pad_px, line_px;

  assign tick   = vs_prev_q & ~VS;
  assign pad_en = (state_q != ST_OVER);

  paddle_ctrl #(.SPEED(PADDLE_SPEED)) u_pad_l (
    .clk   (CLOCK_50),
    .reset (reset),
    .tick  (tick),
    .en    (pad_en),
    .up    (l_up),
    .dn    (l_dn),
    .pad_y (pad_l_y)
  );

  paddle_ctrl #(.SPEED(PADDLE_SPEED)) u_pad_r (
    .clk   (CLOCK_50),
    .reset (reset),
    .tick  (tick),
    .en    (pad_en),
    .up    (r_up),
    .dn    (r_dn),
    .pad_y (pad_r_y)
  );

  // Collision tests use the paddle positions from before this tick's move.
  always_comb begin
    bx_s = signed'({1'b0, bx_q});
    by_s = signed'({2'b00, by_q});
    pl_s = signed'({2'b00, pad_l_y});
    pr_s = signed'({2'b00, pad_r_y});
    nx   = bx_s + (dx_pos_q ? S_SPD : -S_SPD);
    ny   = by_s + (dy_pos_q ? S_SPD : -S_SPD);
    hit_l = !dx_pos_q && (nx <= S_PL_X1) && (bx_s > S_PL_X1) &&
            (ny + S_B7 >= pl_s) && (ny <= pl_s + S_PH1);
    hit_r = dx_pos_q && (nx + S_B7 >= S_PR_X0) && (bx_s + S_B7 < S_PR_X0) &&
            (ny + S_B7 >= pr_s) && (ny <= pr_s + S_PH1);
    miss_l = (nx < 11'sd0);
    miss_r = (nx > S_X_MAX);
  end

  always_comb begin
    state_d   = state_q;
    bx_d      = bx_q;
    by_d      = by_q;
    dx_pos_d  = dx_pos_q;
    dy_pos_d  = dy_pos_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    hold_d    = hold_q;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (serve) state_d = ST_PLAY;
        end
        ST_PLAY: begin
          if (ny < 11'sd0) begin
            by_d     = 9'd0;
            dy_pos_d = !dy_pos_q;
          end else if (ny > S_Y_MAX) begin
            by_d     = 9'(BALL_Y_MAX);
            dy_pos_d = !dy_pos_q;
          end else begin
            by_d = ny[8:0];
          end
          if (hit_l) begin
            bx_d     = 10'(PAD_L_X1 + 1);
            dx_pos_d = 1'b1;
          end else if (hit_r) begin
            bx_d     = 10'(PAD_R_X0 - BALL_SIZE);
            dx_pos_d = 1'b0;
          end else if (miss_l) begin
            score_r_d = sat_inc4(score_r_q);
            dx_pos_d  = 1'b0;
            hold_d    = HW'(POINT_HOLD - 1);
            state_d   = (score_r_d == 4'(WIN_SCORE)) ? ST_OVER : ST_POINT;
          end else if (miss_r) begin
            score_l_d = sat_inc4(score_l_q);
            dx_pos_d  = 1'b1;
            hold_d    = HW'(POINT_HOLD - 1);
            state_d   = (score_l_d == 4'(WIN_SCORE)) ? ST_OVER : ST_POINT;
          end else begin
            bx_d = nx[9:0];
          end
        end
        ST_POINT: begin
          // hold_q was loaded with POINT_HOLD-1, so the last tick sees zero
          if (hold_q == '0) begin
            bx_d     = 10'(BALL_X_C);
            by_d     = 9'(BALL_Y_C);
            dy_pos_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            hold_d = hold_q - HW'(1);
          end
        end
        ST_OVER: begin
          if (serve) begin
            score_l_d = 4'd0;
            score_r_d = 4'd0;
            bx_d      = 10'(BALL_X_C);
            by_d      = 9'(BALL_Y_C);
            state_d   = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    game_over_d = (state_d == ST_OVER);
  end

  always_comb begin
    ball_px = ({1'b0, col} >= {1'b0, bx_q}) &&
              ({1'b0, col} <= {1'b0, bx_q} + 11'(BALL_SIZE - 1)) &&
              ({1'b0, row} >= {1'b0, by_q}) &&
              ({1'b0, row} <= {1'b0, by_q} + 10'(BALL_SIZE - 1));
    pad_px  = ((col >= 10'(PAD_L_X0)) && (col <= 10'(PAD_L_X1)) &&
               ({1'b0, row} >= {1'b0, pad_l_y}) &&
               ({1'b0, row} <= {1'b0, pad_l_y} + 10'(PAD_H - 1))) ||
              ((col >= 10'(PAD_R_X0)) && (col <= 10'(PAD_R_X1)) &&
               ({1'b0, row} >= {1'b0, pad_r_y}) &&
               ({1'b0, row} <= {1'b0, pad_r_y} + 10'(PAD_H - 1)));
    line_px = ((col == 10'(LINE_X0)) || (col == 10'(LINE_X1))) && !row[3];
    rgb_d = 24'h000000;
    if (!blank) begin
      if (ball_px)      rgb_d = 24'hFFFFFF;
      else if (pad_px)  rgb_d = 24'h00FF00;
      else if (line_px) rgb_d = 24'h808080;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      vs_prev_q   <= 1'b1;
      bx_q        <= 10'(BALL_X_C);
      by_q        <= 9'(BALL_Y_C);
      dx_pos_q    <= 1'b1;
      dy_pos_q    <= 1'b1;
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      hold_q      <= '0;
      game_over_q <= 1'b0;
      rgb_q       <= 24'h000000;
    end else begin
      state_q     <= state_d;
      vs_prev_q   <= VS;
      bx_q        <= bx_d;
      by_q        <= by_d;
      dx_pos_q    <= dx_pos_d;
      dy_pos_q    <= dy_pos_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      hold_q      <= hold_d;
      game_over_q <= game_over_d;
      rgb_q       <= rgb_d;
    end
  end

  assign red       = rgb_q[23:16];
  assign green     = rgb_q[15:8];
  assign blue      = rgb_q[7:0];
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_pong_engine.sv
// Randomised bench: a frame-level game model predicts every output cycle and
// a monitor checks the DUT against the queued predictions.
module tb_pong_engine;

  localparam int WIN   = 7;
  localparam int BS    = 2;
  localparam int PS    = 4;
  localparam int HOLD  = 60;
  localparam int NTICK = 5000;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1, VS = 1'b1, blank = 1'b0;
  logic [8:0] row = '0;
  logic [9:0] col = '0;
  logic       l_up = 0, l_dn = 0, r_up = 0, r_dn = 0, serve = 0;
  logic [7:0] red, green, blue;
  logic [3:0] score_l, score_r;
  logic       game_over;

  always #10 CLOCK_50 = ~CLOCK_50;

  pong_engine #(
    .WIN_SCORE(WIN), .BALL_SPEED(BS), .PADDLE_SPEED(PS), .POINT_HOLD(HOLD)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .VS(VS), .blank(blank),
    .row(row), .col(col),
    .l_up(l_up), .l_dn(l_dn), .r_up(r_up), .r_dn(r_dn), .serve(serve),
    .red(red), .green(green), .blue(blue),
    .score_l(score_l), .score_r(score_r), .game_over(game_over)
  );

  typedef struct {
    logic [23:0] rgb;
    logic [3:0]  sl;
    logic [3:0]  sr;
    logic        go;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   n_over = 0;

  // game model: 0 idle, 1 play, 2 point, 3 over
  int m_st, m_bx, m_by, m_dx, m_dy, m_pl, m_pr, m_sl, m_sr, m_hold;
  bit m_vsp;

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic int rrow();
    return int'($urandom_range(0, 479));
  endfunction

  function automatic int rcol();
    return int'($urandom_range(0, 639));
  endfunction

  task automatic model_reset();
    m_st = 0; m_bx = 316; m_by = 236; m_dx = BS; m_dy = BS;
    m_pl = 208; m_pr = 208; m_sl = 0; m_sr = 0; m_hold = 0; m_vsp = 1;
  endtask

  function automatic int pad_step(input int p, input bit u, input bit d);
    if (u && !d) return (p - PS < 0) ? 0 : p - PS;
    if (d && !u) return (p + PS > 416) ? 416 : p + PS;
    return p;
  endfunction

  function automatic logic [23:0] m_pix(input int r, input int c, input bit bl);
    if (bl) return 24'h000000;
    if (c >= m_bx && c <= m_bx + 7 && r >= m_by && r <= m_by + 7) return 24'hFFFFFF;
    if ((c >= 16 && c <= 23 && r >= m_pl && r <= m_pl + 63) ||
        (c >= 616 && c <= 623 && r >= m_pr && r <= m_pr + 63)) return 24'h00FF00;
    if ((c == 319 || c == 320) && ((r / 8) % 2 == 0)) return 24'h808080;
    return 24'h000000;
  endfunction

  task automatic model_tick(input bit lu, input bit ld, input bit ru, input bit rd, input bit sv);
    int nx, ny, opl, opr, st0;
    bit hl, hr;
    opl = m_pl; opr = m_pr; st0 = m_st;
    case (m_st)
      0: if (sv) m_st = 1;
      1: begin
        nx = m_bx + m_dx;
        ny = m_by + m_dy;
        if (ny < 0) begin m_by = 0; m_dy = -m_dy; end
        else if (ny > 472) begin m_by = 472; m_dy = -m_dy; end
        else m_by = ny;
        hl = (m_dx < 0) && (nx <= 23) && (m_bx >= 24) && (ny + 7 >= opl) && (ny <= opl + 63);
        hr = (m_dx > 0) && (nx + 7 >= 616) && (m_bx + 7 <= 615) && (ny + 7 >= opr) && (ny <= opr + 63);
        if (hl) begin m_bx = 24; m_dx = BS; end
        else if (hr) begin m_bx = 608; m_dx = -BS; end
        else if (nx < 0) begin
          m_sr = (m_sr < 15) ? m_sr + 1 : 15;
          m_dx = -BS; m_hold = 0;
          m_st = (m_sr == WIN) ? 3 : 2;
        end else if (nx > 632) begin
          m_sl = (m_sl < 15) ? m_sl + 1 : 15;
          m_dx = BS; m_hold = 0;
          m_st = (m_sl == WIN) ? 3 : 2;
        end else m_bx = nx;
        if (m_st == 3) n_over++;
      end
      2: begin
        m_hold++;
        if (m_hold == HOLD) begin
          m_bx = 316; m_by = 236; m_dy = BS; m_st = 0;
        end
      end
      default: if (sv) begin
        m_sl = 0; m_sr = 0; m_bx = 316; m_by = 236; m_st = 0;
      end
    endcase
    if (st0 != 3) begin
      m_pl = pad_step(opl, lu, ld);
      m_pr = pad_step(opr, ru, rd);
    end
  endtask

  task automatic cyc(input bit rst, input bit vs, input bit bl, input int r, input int c,
                     input bit lu, input bit ld, input bit ru, input bit rd, input bit sv);
    exp_t e;
    logic [23:0] px;
    @(negedge CLOCK_50);
    reset = rst; VS = vs; blank = bl; row = 9'(r); col = 10'(c);
    l_up = lu; l_dn = ld; r_up = ru; r_dn = rd; serve = sv;
    if (rst) begin
      model_reset();
      e.rgb = 24'h000000; e.sl = 4'd0; e.sr = 4'd0; e.go = 1'b0;
    end else begin
      px = m_pix(r, c, bl);
      if (m_vsp && !vs) model_tick(lu, ld, ru, rd, sv);
      m_vsp = vs;
      e.rgb = px; e.sl = 4'(m_sl); e.sr = 4'(m_sr); e.go = (m_st == 3);
    end
    exp_q.push_back(e);
  endtask

  task automatic probe(input int r, input int c);
    if (r >= 0 && r <= 479 && c >= 0 && c <= 639)
      cyc(0, 1, ($urandom_range(0, 7) == 0), r, c, rb(), rb(), rb(), rb(), rb());
  endtask

  task automatic frame(input bit lu, input bit ld, input bit ru, input bit rd, input bit sv);
    cyc(0, 0, rb(), rrow(), rcol(), lu, ld, ru, rd, sv);
    cyc(0, 0, rb(), rrow(), rcol(), rb(), rb(), rb(), rb(), rb());
    probe(m_by, m_bx);
    probe(m_by + 7, m_bx + 7);
    probe(m_by + 3, m_bx + 8);
    probe(m_by + 8, m_bx + 3);
    probe(m_pl, 16);
    probe(m_pl + 64, 23);
    probe(m_pr + 63, 616);
    probe(m_pr - 1, 620);
    probe(rrow(), rcol());
    probe(rrow(), 319 + int'(rb()));
  endtask

  task automatic track(input bit aw, input int py, output bit u, output bit d);
    int ctr, tgt;
    ctr = py + 32;
    tgt = m_by + 4;
    if (aw) begin
      u = (tgt < ctr - 2);
      d = (tgt > ctr + 2);
    end else begin
      u = rb();
      d = rb();
    end
  endtask

  always @(posedge CLOCK_50) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if ({red, green, blue} !== e.rgb) begin
        bad++;
        $display("FAIL pixel: got %06h want %06h at %0t", {red, green, blue}, e.rgb, $time);
      end
      total++;
      if ({score_l, score_r, game_over} !== {e.sl, e.sr, e.go}) begin
        bad++;
        $display("FAIL status: got sl=%0d sr=%0d go=%0b want sl=%0d sr=%0d go=%0b at %0t",
                 score_l, score_r, game_over, e.sl, e.sr, e.go, $time);
      end
    end
  end

  initial begin : stim
    bit lu, ld, ru, rd, sv, aw_l, aw_r;
    aw_l = 0; aw_r = 0;
    model_reset();
    repeat (3) cyc(1, 1, 0, rrow(), rcol(), 0, 0, 0, 0, 0);
    probe(236, 316);
    probe(243, 323);
    probe(235, 316);
    probe(208, 20);
    probe(272, 620);
    // one idle frame without serve: ball must stay parked
    frame(0, 0, 0, 0, 0);
    for (int t = 0; t < NTICK; t++) begin
      if (m_st != 1 || $urandom_range(0, 199) == 0) begin
        aw_l = ($urandom_range(0, 1) == 0);
        aw_r = ($urandom_range(0, 3) == 0);
      end
      track(aw_l, m_pl, lu, ld);
      track(aw_r, m_pr, ru, rd);
      if ($urandom_range(0, 19) == 0) begin lu = 1; ld = 1; end
      sv = ($urandom_range(0, 3) == 0);
      // reset that swallows a VS fall, with VS still low afterwards
      if (t == 400) cyc(1, 0, 0, rrow(), rcol(), rb(), rb(), rb(), rb(), 1);
      frame(lu, ld, ru, rd, sv);
    end
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge CLOCK_50);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("games ended in model: %0d", n_over);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
